// File: rtl/fir_pkg.sv
// fir_pkg: shared FIR widths, requant defaults and the round/shift/saturate function
// Contents: FIR_DIN_W, FIR_COEF_W, FIR_DOUT_W, REQ_DOUT_W, REQ_SHIFT, requant().
// Macro FIR_REQ_ROUND_EN: defined adds the half-LSB offset before the shift (round-half-up), else truncate.
package fir_pkg;
    localparam int FIR_DIN_W  = 8;
    localparam int FIR_COEF_W = 8;
    localparam int FIR_DOUT_W = 16;
    localparam int REQ_DOUT_W = 8;
    localparam int REQ_SHIFT  = 8;

    // The extra top bit keeps the rounding carry so near-full-scale inputs saturate instead of wrapping.
    function automatic logic [31:0] requant(input logic [31:0] d, input int shift, input int dout_w);
        logic [32:0] r;
        logic [32:0] m;
        r = {1'b0, d};
`ifdef FIR_REQ_ROUND_EN
        if (shift > 0) r = r + (33'd1 << (shift - 1));
`endif
        r = r >> shift;
        m = (33'd1 << dout_w) - 33'd1;
        return (r > m) ? m[31:0] : r[31:0];
    endfunction
endpackage

// File: rtl/fir_req_fifo.sv
// fir_req_fifo: synchronous FIFO with wrap-bit pointers
// Ports: clk, reset_n (async active-low); push/din write side; pop/dout read side (dout is the head entry);
//        count occupancy, full, empty.
module fir_req_fifo
    import fir_pkg::*;
#(
    parameter int W     = REQ_DOUT_W,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic [W-1:0]               din,
    input  logic                       pop,
    output logic [W-1:0]               dout,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wp, rp;

    assign count = wp - rp;
    assign empty = wp == rp;
    // Full when the indices match but the wrap bits differ.
    assign full  = (wp ^ rp) == {1'b1, {AW{1'b0}}};
    assign dout  = mem[rp[AW-1:0]];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wp <= '0;
            rp <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) mem[wp[AW-1:0]] <= din;
            wp <= wp + (AW+1)'(push);
            rp <= rp + (AW+1)'(pop);
        end
    end
endmodule

// File: rtl/fir_out_requant.sv
// fir_out_requant: requantise FIR samples to DOUT_W, decimate, buffer and flag drops
// Ports: clk, reset_n (async active-low); en, decim, in_valid, in_data (input stream, never stalled);
//        out_valid/out_ready/out_data (FIFO head), count (occupancy), ovf (sticky drop flag), clr_ovf.
// Macro FIR_REQ_ROUND_EN: round-half-up when defined, truncation otherwise.
module fir_out_requant
    import fir_pkg::*;
#(
    parameter int DIN_W      = FIR_DOUT_W,
    parameter int DOUT_W     = REQ_DOUT_W,
    parameter int SHIFT      = REQ_SHIFT,
    parameter int FIFO_DEPTH = 4,
    parameter int DEC_W      = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          en,
    input  logic [DEC_W-1:0]              decim,
    input  logic                          in_valid,
    input  logic [DIN_W-1:0]              in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DOUT_W-1:0]             out_data,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          ovf,
    input  logic                          clr_ovf
);
    logic [DEC_W-1:0]  cnt;
    logic [DOUT_W-1:0] q, s1_q;
    logic              s1_valid, push, pop, full, empty;

    assign q         = DOUT_W'(requant(32'(in_data), SHIFT, DOUT_W));
    assign out_valid = ~empty;
    assign pop       = out_valid & out_ready;
    // A pop on the same edge frees the slot, so a full FIFO still accepts.
    assign push      = s1_valid & (~full | pop);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt      <= '0;
            s1_valid <= 1'b0;
            s1_q     <= '0;
            ovf      <= 1'b0;
        end else begin
            // >= rather than == so a decim decrease below cnt still wraps.
            cnt      <= !en ? '0 : in_valid ? ((cnt >= decim) ? '0 : cnt + 1'b1) : cnt;
            s1_valid <= en & in_valid & (cnt == '0);
            s1_q     <= q;
            ovf      <= (s1_valid & full & ~pop) | (ovf & ~clr_ovf);
        end
    end

    fir_req_fifo #(.W(DOUT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .din     (s1_q),
        .pop     (pop),
        .dout    (out_data),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );
endmodule

// File: tb/tb_fir_out_requant.sv
// tb_fir_out_requant: directed self-checking bench for fir_out_requant
module tb_fir_out_requant;
    logic        clk = 0, reset_n = 0, en = 0, in_valid = 0, out_ready = 0, clr_ovf = 0;
    logic [3:0]  decim = 0;
    logic [15:0] in_data = 0;
    logic        out_valid, ovf;
    logic [7:0]  out_data;
    logic [2:0]  count;
    int          checks = 0, errors = 0;

`ifdef FIR_REQ_ROUND_EN
    localparam logic [7:0] EXP_180 = 8'h02;
    localparam logic [7:0] EXP_080 = 8'h01;
`else
    localparam logic [7:0] EXP_180 = 8'h01;
    localparam logic [7:0] EXP_080 = 8'h00;
`endif

    always #5 clk = ~clk;

    fir_out_requant dut (
        .clk(clk), .reset_n(reset_n), .en(en), .decim(decim), .in_valid(in_valid),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .count(count), .ovf(ovf), .clr_ovf(clr_ovf)
    );

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic test_reset;
        reset_n = 0; en = 1;
        tick; tick;
        checks++; if (out_valid !== 1'b0 || count !== 3'd0 || ovf !== 1'b0 || out_data !== 8'h00) begin
            errors++; $display("FAIL reset_init got v=%b c=%0d o=%b d=%h exp 0 0 0 00", out_valid, count, ovf, out_data);
        end
        reset_n = 1;
        for (int k = 3; k <= 5; k++) begin
            in_valid = 1; in_data = 16'(k * 256); tick;
        end
        in_valid = 0; tick; tick;
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL reset_fill count got %0d exp 3", count); end
        @(posedge clk); #2 reset_n = 0; #1;
        checks++; if (out_valid !== 1'b0 || count !== 3'd0 || ovf !== 1'b0 || out_data !== 8'h00) begin
            errors++; $display("FAIL reset_async got v=%b c=%0d o=%b d=%h exp 0 0 0 00", out_valid, count, ovf, out_data);
        end
        tick; reset_n = 1; tick;
    endtask

    task automatic send_chk(input logic [15:0] d, input logic [7:0] e, input string nm);
        in_valid = 1; in_data = d; tick;
        in_valid = 0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL %s early_valid got %b exp 0", nm, out_valid); end
        tick;
        checks++; if (out_valid !== 1'b1 || out_data !== e) begin
            errors++; $display("FAIL %s got v=%b d=%h exp v=1 d=%h", nm, out_valid, out_data, e);
        end
        tick;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL %s drain got v=%b exp 0", nm, out_valid); end
    endtask

    task automatic test_latency;
        decim = 0; out_ready = 1;
        send_chk(16'h0180, EXP_180, "latency_0180");
    endtask

    task automatic test_requant;
        send_chk(16'hFFC0, 8'hFF, "sat_FFC0");
        send_chk(16'h007F, 8'h00, "round_007F");
        send_chk(16'h0080, EXP_080, "round_0080");
    endtask

    task automatic test_decim;
        logic [7:0] exp_q [3] = '{8'h01, 8'h04, 8'h07};
        decim = 2; out_ready = 0;
        for (int k = 1; k <= 9; k++) begin
            in_valid = 1; in_data = 16'(k * 256); tick;
        end
        in_valid = 0; tick; tick;
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL decim_count got %0d exp 3", count); end
        out_ready = 1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (out_valid !== 1'b1 || out_data !== exp_q[i]) begin
                errors++; $display("FAIL decim_out%0d got v=%b d=%h exp %h", i, out_valid, out_data, exp_q[i]);
            end
            tick;
        end
        out_ready = 0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL decim_empty got v=%b exp 0", out_valid); end
        decim = 0;
    endtask

    task automatic test_overflow;
        out_ready = 0;
        for (int k = 1; k <= 6; k++) begin
            in_valid = 1; in_data = 16'(k * 256); tick;
        end
        in_valid = 0; tick;
        checks++; if (count !== 3'd4 || ovf !== 1'b1) begin
            errors++; $display("FAIL ovf_set got c=%0d o=%b exp c=4 o=1", count, ovf);
        end
        clr_ovf = 1; tick; clr_ovf = 0;
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_clr got %b exp 0", ovf); end
        in_valid = 1; in_data = 16'h0900; tick;
        in_valid = 0; clr_ovf = 1; tick; clr_ovf = 0;
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_drop_beats_clr got %b exp 1", ovf); end
        clr_ovf = 1; tick; clr_ovf = 0;
        out_ready = 1;
        for (int k = 1; k <= 4; k++) begin
            checks++; if (out_valid !== 1'b1 || out_data !== 8'(k)) begin
                errors++; $display("FAIL ovf_drain%0d got v=%b d=%h exp %h", k, out_valid, out_data, 8'(k));
            end
            tick;
        end
        out_ready = 0;
        checks++; if (count !== 3'd0 || ovf !== 1'b0) begin
            errors++; $display("FAIL ovf_end got c=%0d o=%b exp 0 0", count, ovf);
        end
    endtask

    task automatic test_full_pass;
        out_ready = 0;
        for (int k = 10; k <= 14; k++) begin
            in_valid = 1; in_data = 16'(k * 256); tick;
        end
        in_valid = 0; out_ready = 1;
        checks++; if (count !== 3'd4 || out_data !== 8'd10) begin
            errors++; $display("FAIL full_pre got c=%0d d=%h exp 4 0a", count, out_data);
        end
        tick; out_ready = 0;
        checks++; if (count !== 3'd4 || ovf !== 1'b0 || out_data !== 8'd11) begin
            errors++; $display("FAIL full_pass got c=%0d o=%b d=%h exp 4 0 0b", count, ovf, out_data);
        end
    endtask

    task automatic test_en_drain;
        en = 0; in_valid = 1; in_data = 16'h2000; out_ready = 1;
        for (int k = 11; k <= 14; k++) begin
            checks++; if (out_valid !== 1'b1 || out_data !== 8'(k)) begin
                errors++; $display("FAIL en_drain%0d got v=%b d=%h exp %h", k, out_valid, out_data, 8'(k));
            end
            tick;
        end
        checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL en_empty got c=%0d v=%b exp 0 0", count, out_valid);
        end
        tick; tick; tick;
        checks++; if (count !== 3'd0 || ovf !== 1'b0) begin
            errors++; $display("FAIL en_ignored got c=%0d o=%b exp 0 0", count, ovf);
        end
        in_valid = 0; en = 1; out_ready = 0;
    endtask

    initial begin
        test_reset;
        test_latency;
        test_requant;
        test_decim;
        test_overflow;
        test_full_pass;
        test_en_drain;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fir_out_requant.md
Name: fir_out_requant

Overview:
- Downstream stage of the FIR filter; consumes its 16-bit dout stream.
- Rounds and saturates each sample to 8 bits, then decimates by a programmable factor.
- Buffers results in a small FIFO and presents them on a valid/ready interface to the next consumer.
- Flags dropped samples with a sticky overflow bit.

Parameters:
DIN_W, 16, input sample width (matches FIR dout)
DOUT_W, 8, output sample width
SHIFT, 8, right-shift applied before saturation
FIFO_DEPTH, 4, output FIFO entries; must be a power of two, >= 2
DEC_W, 4, width of the decimation control

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
en  input  1  block enable
decim  input  DEC_W  keep 1 of every decim+1 accepted samples
in_valid  input  1  in_data is a valid sample this cycle; tie high when FIR runs every cycle
in_data  input  DIN_W  unsigned FIR output sample
out_valid  output  1  FIFO non-empty
out_ready  input  1  consumer accepts out_data this cycle
out_data  output  DOUT_W  FIFO head sample
count  output  log2(FIFO_DEPTH)+1  current FIFO occupancy
ovf  output  1  sticky overflow; set when a sample is dropped
clr_ovf  input  1  synchronous clear of ovf

Behaviour:
- Reset, asynchronous on reset_n low:
  - all state clears: out_valid=0, out_data=0, count=0, ovf=0;
  - decimation counter=0; stage-1 valid=0; FIFO pointers=0.
  - Reset asserted mid-operation discards FIFO contents immediately.
- Requant, stage 1 (registered):
  - r = in_data + 2^(SHIFT-1), computed in DIN_W+1 bits (no wrap), then q = r >> SHIFT.
  - If q > 2^DOUT_W-1, saturate to all-ones.
- Decimation counter cnt:
  - Updates only on cycles with en=1 and in_valid=1.
  - The sample is kept when cnt==0.
  - cnt increments; it returns to 0 when cnt >= decim.
  - decim=0 keeps every sample. A decim change takes effect at the next wrap; cnt is never compared beyond the new value without wrapping.
- Stage-1 register captures q and s1_valid = en & in_valid & (cnt==0) on each edge.
- With en=0: input is ignored, cnt is forced to 0, s1_valid=0, and the FIFO continues draining.
- FIFO write:
  - occurs on an edge with s1_valid=1 and (not full, or full with a simultaneous pop).
  - If s1_valid=1, FIFO full, and no pop: the sample is dropped and ovf is set.
- FIFO pop occurs on an edge with out_valid & out_ready.
- Push and pop on the same edge: count is unchanged and both pointers advance.
- out_data is the combinational read of the head entry; out_valid = (count != 0).
- Pointers are log2(FIFO_DEPTH)+1 bits with wrap bit; full and empty derive from the pointer compare.
- Latency: sample accepted at edge N reaches s1 at edge N; written to FIFO at edge N+1. out_valid rises after edge N+1 if the FIFO was empty (2 cycles).
- ovf: set by a drop, cleared by clr_ovf. A drop in the same cycle as clr_ovf wins, so ovf stays 1.
- Back-pressure never stalls the input; the input has no ready signal by design, because the FIR streams continuously.

Optional Feature:
- Macro FIR_REQ_ROUND_EN.
- Defined: round-half-up as described above.
- Undefined: the rounding offset is omitted, so q = in_data >> SHIFT (truncate); saturation is still applied.
- No port or latency change.

Decomposition:
- Shared package fir_pkg holds:
  - FIR_DIN_W=8, FIR_COEF_W=8, FIR_DOUT_W=16;
  - REQ_DOUT_W and REQ_SHIFT defaults;
  - the requant function (round/shift/saturate) so the reference model in the bench shares it.
- One sub-module: fir_req_fifo.
  - Synchronous FIFO with array, pointers, count, full/empty.
  - Push/pop interface and the same clk/reset_n.
- Top-level holds the decimation counter, stage-1 register and ovf logic.

Test Plan:
1. Assert reset_n=0 with the FIFO holding 3 entries -> out_valid=0, count=0, ovf=0 immediately, without waiting for clk.
2. decim=0, out_ready=1, single in_data=16'h0180 -> out_valid high 2 cycles later with out_data=8'h02 (8'h01 without FIR_REQ_ROUND_EN).
3. in_data=16'hFFC0 -> out_data=8'hFF (saturated); in_data=16'h007F -> 8'h00 (rounded); 16'h0080 -> 8'h01.
4. decim=2, nine consecutive samples 16'h0100..16'h0900 -> outputs exactly 8'h01, 8'h04, 8'h07 in order.
5. out_ready=0, decim=0, six samples 1..6 (x256) -> count=4 and ovf=1 after the 5th; clr_ovf -> ovf=0; then out_ready=1 drains 1,2,3,4.
6. FIFO full with out_ready=1 and s1_valid on the same edge -> no drop, ovf stays 0, count stays 4; en=0 mid-stream -> no new writes, FIFO drains to 0.
